// File: rtl/inst_fetch_if_pkg.sv
//------------------------------------------------------------------------------
// Module   : inst_fetch_if_pkg
// Purpose  : Shared constants and FSM state type for the instruction fetch unit.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package inst_fetch_if_pkg;

   localparam int unsigned ADDR_W_DEF = 32;
   localparam int unsigned DATA_W_DEF = 32;

   localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_WAIT    = 2'd2,
      ST_DISCARD = 2'd3
   } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/inst_fetch_if_out_buf.sv
//------------------------------------------------------------------------------
// Module   : if_out_buf
// Purpose  : Output slot(s) between fetch and decode; 2-entry FIFO when
//            IF_PREFETCH_BUF_EN is defined, single slot otherwise.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module if_out_buf
   import inst_fetch_if_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_push,
   input  logic [DATA_W-1:0] i_data,
   input  logic [ADDR_W-1:0] i_pc,
   input  logic              i_flush,
   input  logic              i_stall,
   output logic              o_free,
   output logic              o_valid,
   output logic [DATA_W-1:0] o_inst,
   output logic [ADDR_W-1:0] o_pc
);

   localparam logic [ADDR_W-1:0] C_RST_PC = ADDR_W'(RESET_VECTOR);

   logic              r_v0;
   logic [DATA_W-1:0] r_inst0;
   logic [ADDR_W-1:0] r_pc0;
   logic              w_pop;

   assign w_pop = r_v0 & ~i_stall;

`ifdef IF_PREFETCH_BUF_EN
   logic              r_v1;
   logic [DATA_W-1:0] r_inst1;
   logic [ADDR_W-1:0] r_pc1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v0    <= 1'b0;
         r_inst0 <= '0;
         r_pc0   <= C_RST_PC;
         r_v1    <= 1'b0;
         r_inst1 <= '0;
         r_pc1   <= C_RST_PC;
      end else if (i_flush) begin
         r_v0 <= 1'b0;
         r_v1 <= 1'b0;
      end else begin
         case ({i_push, w_pop})
            2'b11: begin
               if (r_v1) begin
                  r_inst0 <= r_inst1;
                  r_pc0   <= r_pc1;
                  r_inst1 <= i_data;
                  r_pc1   <= i_pc;
               end else begin
                  r_inst0 <= i_data;
                  r_pc0   <= i_pc;
               end
            end
            2'b10: begin
               if (!r_v0) begin
                  r_inst0 <= i_data;
                  r_pc0   <= i_pc;
                  r_v0    <= 1'b1;
               end else begin
                  r_inst1 <= i_data;
                  r_pc1   <= i_pc;
                  r_v1    <= 1'b1;
               end
            end
            2'b01: begin
               if (r_v1) begin
                  r_inst0 <= r_inst1;
                  r_pc0   <= r_pc1;
                  r_v1    <= 1'b0;
               end else begin
                  r_v0 <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   // Room for one more instruction once the head is leaving or slot 1 is empty.
   assign o_free = ~r_v1 | w_pop;
`else
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v0    <= 1'b0;
         r_inst0 <= '0;
         r_pc0   <= C_RST_PC;
      end else if (i_flush) begin
         r_v0 <= 1'b0;
      end else if (i_push) begin
         r_inst0 <= i_data;
         r_pc0   <= i_pc;
         r_v0    <= 1'b1;
      end else if (w_pop) begin
         r_v0 <= 1'b0;
      end
   end

   assign o_free = ~r_v0 | ~i_stall;
`endif

   assign o_valid = r_v0;
   assign o_inst  = r_inst0;
   assign o_pc    = r_pc0;

endmodule

`default_nettype wire

// File: rtl/inst_fetch_if.sv
//------------------------------------------------------------------------------
// Module   : inst_fetch_if
// Purpose  : SRAM-like instruction fetch FSM feeding decode through if_out_buf.
//            Optional macro IF_PREFETCH_BUF_EN enables a 2-entry output FIFO.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module inst_fetch_if
   import inst_fetch_if_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] pc_i,
   output logic              pc_en_o,
   input  logic              flush_i,
   input  logic              stall_i,
   output logic              inst_req,
   output logic [ADDR_W-1:0] inst_addr,
   input  logic              inst_addr_ok,
   input  logic              inst_data_ok,
   input  logic [DATA_W-1:0] inst_rdata,
   output logic [DATA_W-1:0] inst_o,
   output logic [ADDR_W-1:0] inst_pc_o,
   output logic              inst_valid_o,
   output logic              fetch_stall_o
);

   localparam logic [ADDR_W-1:0] C_RST_PC = ADDR_W'(RESET_VECTOR);

   fetch_state_t      r_state;
   fetch_state_t      w_state_nxt;
   logic [ADDR_W-1:0] r_addr;
   logic              r_flush_pend;
   logic              w_addr_load;
   logic              w_push;
   logic              w_pend_set;
   logic              w_pend_clr;
   logic              w_slot_free;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr       <= C_RST_PC;
         r_flush_pend <= 1'b0;
      end else begin
         if (w_addr_load) begin
            r_addr <= pc_i;
         end
         if (w_pend_clr) begin
            r_flush_pend <= 1'b0;
         end else if (w_pend_set) begin
            r_flush_pend <= 1'b1;
         end
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_addr_load   = 1'b0;
      w_push        = 1'b0;
      w_pend_set    = 1'b0;
      w_pend_clr    = 1'b0;
      inst_req      = 1'b0;
      fetch_stall_o = 1'b1;
      case (r_state)
         ST_IDLE: begin
            fetch_stall_o = 1'b0;
            // pc_i is still the stale PC during a flush; pick up the target next cycle.
            if (w_slot_free && !flush_i) begin
               w_addr_load = 1'b1;
               w_state_nxt = ST_REQ;
            end
         end
         ST_REQ: begin
            inst_req = 1'b1;
            if (inst_addr_ok) begin
               w_pend_clr  = 1'b1;
               w_state_nxt = (flush_i || r_flush_pend) ? ST_DISCARD : ST_WAIT;
            end else if (flush_i) begin
               w_pend_set = 1'b1;
            end
         end
         ST_WAIT: begin
            if (inst_data_ok) begin
               w_push      = ~flush_i;
               w_state_nxt = ST_IDLE;
            end else if (flush_i) begin
               w_state_nxt = ST_DISCARD;
            end
         end
         ST_DISCARD: begin
            if (inst_data_ok) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
      pc_en_o = inst_req & inst_addr_ok & ~flush_i;
   end

   assign inst_addr = r_addr;

   if_out_buf #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_out_buf (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_data  (inst_rdata),
      .i_pc    (r_addr),
      .i_flush (flush_i),
      .i_stall (stall_i),
      .o_free  (w_slot_free),
      .o_valid (inst_valid_o),
      .o_inst  (inst_o),
      .o_pc    (inst_pc_o)
   );

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch_if.sv
//------------------------------------------------------------------------------
// Module   : tb_inst_fetch_if
// Purpose  : Directed self-checking bench for inst_fetch_if.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_inst_fetch_if;

   logic        clk;
   logic        rst_n;
   logic [31:0] pc_i;
   logic        pc_en_o;
   logic        flush_i;
   logic        stall_i;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;
   logic [31:0] inst_o;
   logic [31:0] inst_pc_o;
   logic        inst_valid_o;
   logic        fetch_stall_o;

   int n_chk;
   int n_err;
   int req_cnt;

   inst_fetch_if #(
      .ADDR_W (32),
      .DATA_W (32)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .pc_i          (pc_i),
      .pc_en_o       (pc_en_o),
      .flush_i       (flush_i),
      .stall_i       (stall_i),
      .inst_req      (inst_req),
      .inst_addr     (inst_addr),
      .inst_addr_ok  (inst_addr_ok),
      .inst_data_ok  (inst_data_ok),
      .inst_rdata    (inst_rdata),
      .inst_o        (inst_o),
      .inst_pc_o     (inst_pc_o),
      .inst_valid_o  (inst_valid_o),
      .fetch_stall_o (fetch_stall_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge; inputs are then driven for that cycle.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input logic aok, input logic dok, input logic [31:0] rd,
                      input logic fl, input logic st);
      inst_addr_ok = aok;
      inst_data_ok = dok;
      inst_rdata   = rd;
      flush_i      = fl;
      stall_i      = st;
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      rst_n = 1'b0;
      pc_i  = 32'hBFC0_0000;
      drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      tick();
      tick();
      #1;
      check("rst_req",   {63'd0, inst_req},      64'd0);
      check("rst_pcen",  {63'd0, pc_en_o},       64'd0);
      check("rst_valid", {63'd0, inst_valid_o},  64'd0);
      check("rst_fstall",{63'd0, fetch_stall_o}, 64'd0);
      check("rst_inst",  {32'd0, inst_o},        64'd0);
      check("rst_ipc",   {32'd0, inst_pc_o},     64'hBFC0_0000);
      check("rst_addr",  {32'd0, inst_addr},     64'hBFC0_0000);

      // Basic fetch: cycle 0 IDLE, addr_ok at cycle 1, data_ok at cycle 3
      tick(); rst_n = 1'b1;
      tick(); drv(1'b1, 1'b0, 32'h0, 1'b0, 1'b0); #1;
      check("c1_req",  {63'd0, inst_req},  64'd1);
      check("c1_addr", {32'd0, inst_addr}, 64'hBFC0_0000);
      check("c1_pcen", {63'd0, pc_en_o},   64'd1);
      tick(); pc_i = 32'hBFC0_0004; drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0); #1;
      check("c2_pcen",   {63'd0, pc_en_o},       64'd0);
      check("c2_fstall", {63'd0, fetch_stall_o}, 64'd1);
      tick(); drv(1'b0, 1'b1, 32'h3C08_0001, 1'b0, 1'b0);
      tick(); drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0); #1;
      check("c4_valid",  {63'd0, inst_valid_o},  64'd1);
      check("c4_inst",   {32'd0, inst_o},        64'h3C08_0001);
      check("c4_ipc",    {32'd0, inst_pc_o},     64'hBFC0_0000);
      check("c4_fstall", {63'd0, fetch_stall_o}, 64'd0);

      // addr_ok withheld for 4 cycles
      for (int i = 0; i < 4; i++) begin
         tick(); drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0); #1;
         check("hold_req",    {63'd0, inst_req},      64'd1);
         check("hold_addr",   {32'd0, inst_addr},     64'hBFC0_0004);
         check("hold_pcen",   {63'd0, pc_en_o},       64'd0);
         check("hold_fstall", {63'd0, fetch_stall_o}, 64'd1);
      end
      check("hold_valid", {63'd0, inst_valid_o}, 64'd0);
      tick(); drv(1'b1, 1'b0, 32'h0, 1'b0, 1'b0); #1;
      check("c9_pcen", {63'd0, pc_en_o}, 64'd1);

      // Flush in WAIT, data two cycles later is dropped
      tick(); pc_i = 32'hBFC0_0008; drv(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      tick(); pc_i = 32'h8000_0100; drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0); #1;
      check("disc_fstall", {63'd0, fetch_stall_o}, 64'd1);
      check("disc_req",    {63'd0, inst_req},      64'd0);
      tick(); drv(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
      tick(); drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0); #1;
      check("disc_valid", {63'd0, inst_valid_o},  64'd0);
      check("disc_idle",  {63'd0, fetch_stall_o}, 64'd0);
      tick(); drv(1'b1, 1'b0, 32'h0, 1'b0, 1'b0); #1;
      check("redir_req",  {63'd0, inst_req},  64'd1);
      check("redir_addr", {32'd0, inst_addr}, 64'h8000_0100);

      // Flush and data_ok in the same cycle
      tick(); pc_i = 32'h8000_0104; drv(1'b0, 1'b1, 32'h1111_1111, 1'b1, 1'b0);
      tick(); pc_i = 32'h9000_0000; drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0); #1;
      check("same_valid",  {63'd0, inst_valid_o},  64'd0);
      check("same_fstall", {63'd0, fetch_stall_o}, 64'd0);
      check("same_req",    {63'd0, inst_req},      64'd0);

      // Stall with a valid slot for 3 cycles
      tick(); drv(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      tick(); pc_i = 32'h9000_0004; drv(1'b0, 1'b1, 32'h2402_0005, 1'b0, 1'b0);
      req_cnt = 0;
      for (int i = 0; i < 3; i++) begin
         tick(); drv(1'b1, 1'b0, 32'h0, 1'b0, 1'b1); #1;
         if (pc_en_o) req_cnt++;
         check("stall_valid", {63'd0, inst_valid_o}, 64'd1);
         check("stall_inst",  {32'd0, inst_o},       64'h2402_0005);
         check("stall_ipc",   {32'd0, inst_pc_o},    64'h9000_0000);
      end
`ifdef IF_PREFETCH_BUF_EN
      check("stall_reqs", 64'(req_cnt), 64'd1);
`else
      check("stall_reqs", 64'(req_cnt), 64'd0);
`endif
      tick(); drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0); #1;
      check("unstall_valid", {63'd0, inst_valid_o}, 64'd1);
      tick(); #1;
      check("drain_valid", {63'd0, inst_valid_o}, 64'd0);

      // Reset while in WAIT, then a stray data_ok
      rst_n = 1'b0;
      tick(); tick();
      rst_n = 1'b1; pc_i = 32'hA000_0000;
      tick(); drv(1'b1, 1'b0, 32'h0, 1'b0, 1'b0); #1;
      check("r2_addr", {32'd0, inst_addr}, 64'hA000_0000);
      tick(); drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      rst_n = 1'b0; #1;
      check("wrst_req",    {63'd0, inst_req},      64'd0);
      check("wrst_fstall", {63'd0, fetch_stall_o}, 64'd0);
      check("wrst_addr",   {32'd0, inst_addr},     64'hBFC0_0000);
      check("wrst_valid",  {63'd0, inst_valid_o},  64'd0);
      tick();
      rst_n = 1'b1; drv(1'b0, 1'b1, 32'h5555_AAAA, 1'b0, 1'b0);
      tick(); drv(1'b0, 1'b1, 32'h5555_AAAA, 1'b0, 1'b0);
      tick(); drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0); #1;
      check("stray_valid1", {63'd0, inst_valid_o}, 64'd0);
      tick(); #1;
      check("stray_valid2", {63'd0, inst_valid_o}, 64'd0);
      check("stray_req",    {63'd0, inst_req},     64'd1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/inst_fetch_if.md
INST_FETCH_IF -- requirements
Module: inst_fetch_if

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, fetch address width.
REQ-002 SHALL have parameter DATA_W, default 32, instruction width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port pc_i  input  ADDR_W  current fetch PC from the PC register.
REQ-006 SHALL have port pc_en_o  output  1  advance enable to the PC register.
REQ-007 SHALL have port flush_i  input  1  redirect; the PC register loads its target this cycle.
REQ-008 SHALL have port stall_i  input  1  decode cannot accept an instruction.
REQ-009 SHALL have port inst_req  output  1  memory request, SRAM-like.
REQ-010 SHALL have port inst_addr  output  ADDR_W  request address.
REQ-011 SHALL have ports inst_addr_ok  input  1 (address accepted) and inst_data_ok  input  1 (read data returned).
REQ-012 SHALL have port inst_rdata  input  DATA_W  returned instruction.
REQ-013 SHALL have ports inst_o  output  DATA_W, inst_pc_o  output  ADDR_W, inst_valid_o  output  1  instruction delivered to decode.
REQ-014 SHALL have port fetch_stall_o  output  1  high while a request is waiting on memory.

Function
REQ-015 SHALL implement FSM states IDLE, REQ, WAIT, DISCARD.
REQ-016 IDLE->REQ when the output slot is free: latch pc_i into inst_addr and assert inst_req from the next cycle.
REQ-017 In REQ, inst_req and inst_addr SHALL be held stable until inst_addr_ok is sampled high.
REQ-018 pc_en_o SHALL equal inst_req & inst_addr_ok & ~flush_i, giving a one-cycle pulse per accepted address.
REQ-019 On REQ with inst_addr_ok high, go to WAIT, or to DISCARD if flush_i is high or a flush is pending.
REQ-020 A flush in REQ without inst_addr_ok SHALL set a pending-discard flag; the request is not withdrawn.
REQ-021 On WAIT with inst_data_ok high, capture inst_rdata and the request address into the output slot; go to IDLE.
REQ-022 On WAIT with flush_i high and inst_data_ok low, go to DISCARD.
REQ-023 On WAIT with flush_i and inst_data_ok high in the same cycle, drop the data and go to IDLE.
REQ-024 In DISCARD, swallow exactly one inst_data_ok without delivering it, then go to IDLE.
REQ-025 inst_valid_o SHALL stay high with the slot held stable while stall_i is high, and clear one cycle after stall_i is low.
REQ-026 flush_i SHALL clear the output slot (inst_valid_o low next cycle) in every state.
REQ-027 fetch_stall_o SHALL be high in REQ, WAIT and DISCARD.
REQ-028 A new request SHALL NOT be issued while the output slot is occupied and stall_i is high.

Reset
REQ-029 While rst_n is low, the FSM SHALL be IDLE and inst_req, pc_en_o, inst_valid_o, fetch_stall_o SHALL be 0.
REQ-030 While rst_n is low, inst_o SHALL be 0, and inst_pc_o and inst_addr SHALL be RESET_VECTOR (32'hBFC0_0000).
REQ-031 Reset mid-transaction SHALL abandon it; the first inst_data_ok after reset with no request outstanding SHALL be ignored.

Configuration
REQ-032 With macro IF_PREFETCH_BUF_EN defined, a second output slot (2-entry FIFO) SHALL allow one further request while slot 0 is held by stall_i.
REQ-033 With IF_PREFETCH_BUF_EN defined, flush SHALL clear both slots.
REQ-034 Without IF_PREFETCH_BUF_EN, a single slot and the REQ-028 rule apply.

Structure
REQ-035 A shared package SHALL hold RESET_VECTOR, the FSM state typedef and the ADDR_W/DATA_W defaults.
REQ-036 The output slot(s) SHALL be a sub-module if_out_buf; the FSM stays in inst_fetch_if.

Verification
REQ-037 Release reset, pc_i=BFC0_0000, addr_ok at cycle 1, data_ok=1 with rdata=3C08_0001 at cycle 3 -> one pc_en_o pulse; inst_valid_o=1, inst_o=3C08_0001, inst_pc_o=BFC0_0000.
REQ-038 addr_ok withheld 4 cycles -> inst_req and inst_addr stable, pc_en_o=0 and fetch_stall_o=1 for all 4 cycles.
REQ-039 flush_i in WAIT, data_ok 2 cycles later -> data dropped, inst_valid_o=0, next request uses the redirected pc_i.
REQ-040 flush_i and data_ok in the same cycle -> no delivery, FSM in IDLE next cycle.
REQ-041 stall_i high 3 cycles with a valid slot -> inst_o held; no new inst_req without IF_PREFETCH_BUF_EN, exactly one with it.
REQ-042 rst_n low while in WAIT -> outputs at reset values; a stray data_ok after release produces no inst_valid_o.
